// File: rtl/dmem_lsu.sv
// Load/store unit between the core memory stage and a word-only data memory.
// Handles sub-word loads with extension and sub-word stores via read-modify-write.
module dmem_lsu #(
    parameter int unsigned MEM_BYTES = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        StIdle, StLoad, StRmwRd, StWrite, StResp, StErr
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        err_q, err_d;

    logic        req_bad;
    logic [4:0]  shamt;
    logic [31:0] lane;
    logic [31:0] load_data;
    logic [31:0] lane_mask;
    logic [31:0] merged;

    // Full 32-bit compare so high addresses never alias into the RAM.
    assign req_bad = (req_size == 2'b11)
                   | ((req_size == 2'b01) & req_addr[0])
                   | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
                   | (req_addr >= MEM_BYTES);

    assign shamt = {addr_q[1:0], 3'b000};
    assign lane  = mem_rdata >> shamt;

    always_comb begin
        load_data = lane;
        case (size_q)
            2'b00:   load_data = uns_q ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
            2'b01:   load_data = uns_q ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: load_data = lane;
        endcase
    end

    assign lane_mask = ((size_q == 2'b00) ? 32'h0000_00ff : 32'h0000_ffff) << shamt;
    assign merged    = (mem_rdata & ~lane_mask) | ((wdata_q << shamt) & lane_mask);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    if (req_bad) begin
                        state_d = StErr;
                    end else if (!req_we) begin
                        state_d = StLoad;
                    end else if (req_size == 2'b10) begin
                        buf_d   = req_wdata;
                        state_d = StWrite;
                    end else begin
                        state_d = StRmwRd;
                    end
                end
            end
            StLoad: begin
                rdata_d = load_data;
                err_d   = 1'b0;
                state_d = StResp;
            end
            StRmwRd: begin
                buf_d   = merged;
                state_d = StWrite;
            end
            StWrite: begin
                rdata_d = 32'h0;
                err_d   = 1'b0;
                state_d = StResp;
            end
            StErr: begin
                rdata_d = 32'h0;
                err_d   = 1'b1;
                state_d = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            buf_q   <= 32'h0;
            rdata_q <= 32'h0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
        end
    end

    // Memory-side outputs come from registered state only.
    always_comb begin
        req_ready  = (state_q == StIdle);
        resp_valid = (state_q == StResp);
        resp_err   = (state_q == StResp) & err_q;
        resp_rdata = rdata_q;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        mem_we     = 1'b0;
        if (state_q == StLoad || state_q == StRmwRd || state_q == StWrite) begin
            mem_addr = {addr_q[31:2], 2'b00};
        end
        if (state_q == StWrite) begin
            mem_wdata = buf_q;
            mem_we    = 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: byte-array reference model, randomized and directed traffic.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    dmem_lsu #(.MEM_BYTES(2048)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Word RAM seen by the DUT, and the byte-wise reference image.
    logic [31:0] ram [512];
    logic [7:0]  refmem [2048];
    assign mem_rdata = ram[mem_addr[10:2]];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          edges;
        int          we_cycles;
        logic [31:0] waddr;
        logic [31:0] wword;
        int          acc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          n_total = 0;
    int          n_pass = 0;
    int          n_issued = 0;
    int          n_resp = 0;
    int          we_cnt = 0;
    logic [31:0] last_rdata = 32'h0;
    logic        last_err = 1'b0;
    logic [31:0] last_wword = 32'h0;
    bit          chain = 1'b0;
    int          prev_acc = 0;
    int          prev_period = 0;

    initial begin
        for (int i = 0; i < 512; i++) begin
            logic [31:0] w;
            w = $urandom;
            ram[i] = w;
            for (int b = 0; b < 4; b++) refmem[4 * i + b] = w[8 * b +: 8];
        end
        forever begin
            @(posedge clk);
            if (mem_we) ram[mem_addr[10:2]] = mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic abort_run(input string why);
        n_total++;
        $display("FAIL %s: timed out", why);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "bench stopped");
    endtask

    // Reference behaviour; stores update the byte image at acceptance.
    function automatic exp_t model(input bit we, input logic [1:0] size, input bit uns,
                                   input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int   nb;
        int   base;
        int   wb;
        e.rdata = 32'h0; e.err = 1'b0; e.edges = 2; e.we_cycles = 0;
        e.waddr = 32'h0; e.wword = 32'h0; e.acc = 0;
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        e.err = (size == 2'd3) || (size == 2'd1 && a[0]) || (size == 2'd2 && a[1:0] != 2'd0)
                || (a >= 32'd2048);
        if (e.err) return e;
        base = int'(a);
        if (!we) begin
            for (int b = 0; b < nb; b++) e.rdata |= 32'(refmem[base + b]) << (8 * b);
            if (!uns && nb < 4 && e.rdata[8 * nb - 1]) e.rdata |= 32'hffff_ffff << (8 * nb);
        end else begin
            for (int b = 0; b < nb; b++) refmem[base + b] = wd[8 * b +: 8];
            wb = base & ~3;
            for (int b = 0; b < 4; b++) e.wword |= 32'(refmem[wb + b]) << (8 * b);
            e.waddr = a & ~32'd3;
            e.we_cycles = 1;
            e.edges = (nb == 4) ? 2 : 3;
        end
        return e;
    endfunction

    // Called one time unit after an edge; returns the same phase after acceptance.
    task automatic issue(input bit we, input logic [1:0] size, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd, input bit hold);
        exp_t e;
        int   n;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready) begin
            @(posedge clk); #1;
            n++;
            if (n > 40) abort_run("accept_wait");
        end
        @(posedge clk); #1;
        e = model(we, size, uns, a, wd);
        e.acc = cyc;
        if (chain) check("period", 32'(cyc - prev_acc), 32'(prev_period));
        q.push_back(e);
        n_issued++;
        prev_acc = cyc;
        prev_period = e.edges + 1;
        chain = hold;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (q.size() != 0) begin
            @(posedge clk); #1;
            n++;
            if (n > 40) abort_run("resp_wait");
        end
    endtask

    task automatic dir(input string name, input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rdata, input logic exp_err);
        issue(we, size, uns, a, wd, 1'b0);
        wait_done();
        check({name, "_rdata"}, last_rdata, exp_rdata);
        check({name, "_err"}, 32'(last_err), 32'(exp_err));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        check({tag, "_resp_rdata"}, resp_rdata, 32'h0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    // Store accepted, then reset one cycle later; never pushed to the scoreboard.
    task automatic abort_store(input logic [1:0] size, input logic [31:0] a, input logic exp_we);
        req_we = 1'b1; req_size = size; req_unsigned = 1'b0; req_addr = a;
        req_wdata = $urandom; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("abort_pre_we", 32'(mem_we), 32'(exp_we));
        check("abort_pre_addr", mem_addr, a & ~32'd3);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            we_cnt = 0;
        end else begin
            if (mem_we) begin
                we_cnt++;
                last_wword = mem_wdata;
                if (q.size() != 0) begin
                    check("wr_addr", mem_addr, q[0].waddr);
                    check("wr_data", mem_wdata, q[0].wword);
                end else begin
                    n_total++;
                    $display("FAIL wr_unexpected: got write to 0x%08h, expected none", mem_addr);
                end
            end
            if (resp_valid) begin
                if (q.size() == 0) begin
                    n_total++;
                    $display("FAIL resp_unexpected: got resp_valid, expected none");
                end else begin
                    mon_e = q.pop_front();
                    check("rdata", resp_rdata, mon_e.rdata);
                    check("err", 32'(resp_err), 32'(mon_e.err));
                    // Acceptance edge counts as the first edge.
                    check("latency_edges", 32'(cyc - mon_e.acc + 1), 32'(mon_e.edges));
                    check("we_cycles", 32'(we_cnt), 32'(mon_e.we_cycles));
                end
                last_rdata = resp_rdata;
                last_err = resp_err;
                n_resp++;
                we_cnt = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        abort_run("global_watchdog");
    end

    initial begin
        int nbad;
        logic [31:0] a;
        logic [1:0]  sz;
        int          r;
        bit          h;

        @(posedge clk); #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        dir("st_word", 1'b1, 2'd2, 1'b0, 32'h10, 32'hdead_beef, 32'h0, 1'b0);
        check("st_word_wdata", last_wword, 32'hdead_beef);
        dir("ld_word", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hdead_beef, 1'b0);
        dir("ld_byte_s", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'hffff_ffde, 1'b0);
        dir("ld_byte_u", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h0000_00de, 1'b0);
        dir("ld_half_s", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'hffff_dead, 1'b0);
        dir("st_byte", 1'b1, 2'd0, 1'b0, 32'h11, 32'h55, 32'h0, 1'b0);
        check("st_byte_merge", last_wword, 32'hdead_55ef);
        dir("reload", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hdead_55ef, 1'b0);
        dir("err_half", 1'b0, 2'd1, 1'b0, 32'h21, 32'h0, 32'h0, 1'b1);
        dir("err_word_st", 1'b1, 2'd2, 1'b0, 32'h22, 32'h1234_5678, 32'h0, 1'b1);
        dir("err_size", 1'b0, 2'd3, 1'b0, 32'h30, 32'h0, 32'h0, 1'b1);
        dir("err_range", 1'b0, 2'd0, 1'b0, 32'h800, 32'h0, 32'h0, 1'b1);
        dir("st_top", 1'b1, 2'd0, 1'b0, 32'h7ff, 32'hffff_ffa5, 32'h0, 1'b0);
        dir("ld_top", 1'b0, 2'd0, 1'b1, 32'h7ff, 32'h0, 32'h0000_00a5, 1'b0);

        // req_valid held high, alternating store and load to the same word.
        for (int i = 0; i < 8; i++) begin
            issue((i % 2) == 0, 2'd2, 1'b0, 32'h100 + 32'(4 * (i / 2)), $urandom, i != 7);
        end
        wait_done();

        // Random traffic, partly back-to-back.
        for (int i = 0; i < 160; i++) begin
            h = ($urandom_range(0, 2) != 0) && (i != 159);
            r = int'($urandom_range(0, 9));
            sz = (r == 9) ? 2'd3 : 2'(r % 3);
            r = int'($urandom_range(0, 9));
            if (r < 7) a = 32'($urandom_range(0, 127));
            else if (r < 9) a = 32'h7f0 + 32'($urandom_range(0, 15));
            else if ($urandom_range(0, 1) == 0) a = 32'h800 + 32'($urandom_range(0, 8));
            else a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ((sz == 2'd1) ? ~32'd1 : ~32'd3);
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, h);
            if (!h) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
        end
        wait_done();

        // Load first so resp_rdata is non-zero when reset hits.
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
        wait_done();
        abort_store(2'd1, 32'h40, 1'b0);
        abort_store(2'd2, 32'h44, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 1'b0);
        wait_done();
        repeat (4) begin @(posedge clk); #1; end

        check("resp_count", 32'(n_resp), 32'(n_issued));
        nbad = 0;
        for (int i = 0; i < 512; i++) begin
            if (ram[i] !== {refmem[4 * i + 3], refmem[4 * i + 2], refmem[4 * i + 1], refmem[4 * i]})
                nbad++;
        end
        check("ram_mismatch_words", 32'(nbad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit sitting between the core's memory stage and the word-only data memory. Accepts byte, halfword and word load/store requests over a valid/ready handshake and drives the memory's word address, write data and write enable. Performs alignment and range checking, sign/zero extension of loads, and read-modify-write for sub-word stores, since the data memory has no byte enables. Read data from the memory is combinational (same-cycle) and writes commit on the rising clock edge.

## Interface
- MEM_BYTES, 2048: size of the backing RAM in bytes; addresses at or above this value are errors.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle pulse: request complete.
- resp_rdata  out  32  extended load data (0 for stores and errors).
- resp_err  out  1  valid with resp_valid: misaligned, illegal size or out of range.
- mem_addr  out  32  word-aligned address to data memory ({addr[31:2],2'b00}); 0 when idle.
- mem_wdata  out  32  full word to write; 0 when idle.
- mem_we  out  1  write enable, high for exactly one cycle per store.
- mem_rdata  in  32  combinational read data from memory.

## Operation
- States: IDLE, LOAD, RMW_RD, WRITE, RESP, ERR.
- IDLE: req_ready=1. On req_valid, latch addr/size/we/unsigned/wdata and transition:
  - error (size 11; half with addr[0]=1; word with addr[1:0]!=0; addr >= MEM_BYTES) -> ERR. No memory access occurs.
  - load -> LOAD.
  - word store -> WRITE, with merge buffer = wdata.
  - byte or half store -> RMW_RD.
- LOAD: drive mem_addr with mem_we=0. Extract the lane (little-endian: byte at addr[1:0]*8, half at addr[1]*16), extend it per req_unsigned, register it into resp_rdata, -> RESP.
- RMW_RD: drive mem_addr with mem_we=0. Capture mem_rdata into the merge buffer and replace the addressed lane with wdata[7:0] or wdata[15:0], -> WRITE.
- WRITE: drive mem_addr, mem_wdata=merge buffer and mem_we=1, -> RESP.
- ERR: clear resp_rdata and set the error flag, -> RESP.
- RESP: resp_valid=1, resp_err per flag, req_ready=0, -> IDLE. resp_rdata holds its value until the next response.
- No request is accepted in any state except IDLE. Inputs other than mem_rdata are ignored after acceptance.
- Range check uses the full 32-bit address, so there is no wrap-around. An address of MEM_BYTES-1 for a byte access is legal.

## Timing
- Acceptance edge: the rising edge at which req_valid && req_ready.
- resp_valid is high in the cycle starting:
  - 2 edges after acceptance for loads and word stores;
  - 3 edges after acceptance for sub-word stores;
  - 2 edges after acceptance for errors (through ERR).
- Back-to-back throughput: one request per 3 cycles (loads and word stores) or 4 cycles (sub-word stores). req_ready rises in the cycle after resp_valid.
- The store commit is the edge ending the WRITE cycle. A load issued immediately after a store observes the new data.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, internal latches=0.
- Reset asserted mid-operation: the FSM goes to IDLE immediately and mem_we drops asynchronously. A store whose WRITE edge has not yet occurred is not committed. No resp_valid is produced for the aborted request.
- mem_we, mem_addr and mem_wdata are decoded from registered state only, with no combinational path from req_* inputs.

## Test plan
- Word store 0xDEADBEEF to 0x10, then a word load from 0x10:
  - the load returns 0xDEADBEEF with resp_err=0;
  - mem_we is high for exactly 1 cycle;
  - resp_valid arrives 2 edges after each acceptance.
- Byte load from 0x13 (word 0x10 = 0xDEADBEEF), signed: returns 0xFFFFFFDE. Unsigned: returns 0x000000DE. Half load from 0x12, signed: returns 0xFFFFDEAD.
- Byte store 0x55 to 0x11 over 0xDEADBEEF:
  - RMW sequence: one read cycle, then one write cycle with mem_wdata=0xDEAD55EF;
  - resp_valid 3 edges after acceptance;
  - a reload from 0x10 returns 0xDEAD55EF.
- Errors: half load from 0x21, word store to 0x22, size 11, and byte load from 0x800.
  - each returns resp_err=1 and resp_rdata=0;
  - mem_we never asserts;
  - memory is unchanged.
- req_valid held high continuously with alternating load/store: each request is accepted only while req_ready=1, and none is lost or duplicated.
- Assert rst_n low during RMW_RD of a half store to 0x40: no write occurs, no response is produced, all outputs return to reset values, and word 0x40 is unchanged.
